pll_lock_supervisor: RTL and testbench

//  Sits beside a PLL instance, all logic on refclk. Drives the PLL reset, qualifies
//  its locked output, and releases NUM_OUT downstream active-low resets in

---
 rtl/pll_lock_supervisor.sv | 188 ++++++++++++++++++
 tb/tb_pll_lock_supervisor.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_lock_supervisor.sv
`default_nettype none
// ============================================================================
// Module   : pll_lock_supervisor
// Purpose  : PLL reset driver, lock qualifier and staggered downstream reset
//            sequencer with timeout retries and sticky fault reporting.
// Revision : 1.0 - initial release
// ============================================================================
module pll_lock_supervisor #(
    parameter int NUM_OUT         = 4,
    parameter int PLL_RST_CYCLES  = 16,
    parameter int LOCK_FILTER     = 64,
    parameter int LOCK_TIMEOUT    = 65536,
    parameter int STAGGER         = 8,
    parameter int MAX_RETRIES     = 3,
    localparam int RC_W           = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1
) (
    input  logic               refclk,
    input  logic               rst_n,
    input  logic               pll_locked,
    input  logic               force_relock,
    output logic               pll_rst,
    output logic [NUM_OUT-1:0] rst_out_n,
    output logic               ready,
    output logic               fault,
    output logic [RC_W-1:0]    retry_cnt
);

    function automatic int f_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Last RELEASE count value: one cycle past the final bit's release.
    localparam int REL_LAST = (NUM_OUT - 1) * STAGGER + 1;
    localparam int CNT_MAX  = f_max(f_max(PLL_RST_CYCLES, LOCK_TIMEOUT),
                                    f_max(LOCK_FILTER, REL_LAST));
    localparam int CNT_W    = $clog2(CNT_MAX + 1);

    localparam logic [2:0] c_ST_PLL_RESET = 3'd0;
    localparam logic [2:0] c_ST_WAIT_LOCK = 3'd1;
    localparam logic [2:0] c_ST_FILTER    = 3'd2;
    localparam logic [2:0] c_ST_RELEASE   = 3'd3;
    localparam logic [2:0] c_ST_RUN       = 3'd4;
    localparam logic [2:0] c_ST_FAULT     = 3'd5;

    logic [1:0]         r_sync;
    logic               w_locked_s;
    logic [2:0]         r_state;
    logic [2:0]         w_next_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic               w_timeout;
    logic               w_lock_loss;
    logic               w_counting;

    logic               r_pll_rst;
    logic [NUM_OUT-1:0] r_rst_out_n;
    logic               r_ready;
    logic               r_fault;
    logic [RC_W-1:0]    r_retry;
    logic               w_pll_rst_nxt;
    logic [NUM_OUT-1:0] w_rst_out_nxt;
    logic               w_ready_nxt;
    logic               w_fault_nxt;
    logic [RC_W-1:0]    w_retry_nxt;

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[0], pll_locked};
        end
    end

    assign w_locked_s = r_sync[1];

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= c_ST_PLL_RESET;
            r_cnt       <= '0;
            r_pll_rst   <= 1'b1;
            r_rst_out_n <= '0;
            r_ready     <= 1'b0;
            r_fault     <= 1'b0;
            r_retry     <= '0;
        end else begin
            r_state     <= w_next_state;
            r_cnt       <= w_cnt_nxt;
            r_pll_rst   <= w_pll_rst_nxt;
            r_rst_out_n <= w_rst_out_nxt;
            r_ready     <= w_ready_nxt;
            r_fault     <= w_fault_nxt;
            r_retry     <= w_retry_nxt;
        end
    end

    // force_relock outranks every in-state decision, including lock loss.
    always_comb begin
        w_next_state = r_state;
        w_timeout    = 1'b0;
        w_lock_loss  = 1'b0;
        if (force_relock) begin
            w_next_state = c_ST_PLL_RESET;
        end else begin
            case (r_state)
                c_ST_PLL_RESET: begin
                    if (r_cnt == CNT_W'(PLL_RST_CYCLES - 1)) begin
                        w_next_state = c_ST_WAIT_LOCK;
                    end
                end
                c_ST_WAIT_LOCK: begin
                    if (w_locked_s) begin
                        w_next_state = c_ST_FILTER;
                    end else if (r_cnt == CNT_W'(LOCK_TIMEOUT - 1)) begin
                        w_timeout    = 1'b1;
                        w_next_state = (r_retry == RC_W'(MAX_RETRIES)) ? c_ST_FAULT
                                                                       : c_ST_PLL_RESET;
                    end
                end
                c_ST_FILTER: begin
                    if (!w_locked_s) begin
                        w_next_state = c_ST_WAIT_LOCK;
                    end else if (r_cnt == CNT_W'(LOCK_FILTER - 1)) begin
                        w_next_state = c_ST_RELEASE;
                    end
                end
                c_ST_RELEASE: begin
                    if (!w_locked_s) begin
                        w_lock_loss  = 1'b1;
                        w_next_state = c_ST_PLL_RESET;
                    end else if (r_cnt == CNT_W'(REL_LAST)) begin
                        w_next_state = c_ST_RUN;
                    end
                end
                c_ST_RUN: begin
                    if (!w_locked_s) begin
                        w_lock_loss  = 1'b1;
                        w_next_state = c_ST_PLL_RESET;
                    end
                end
                c_ST_FAULT: begin
                    w_next_state = c_ST_FAULT;
                end
                default: begin
                    w_next_state = c_ST_PLL_RESET;
                end
            endcase
        end
    end

    assign w_counting = (r_state != c_ST_RUN) && (r_state != c_ST_FAULT);

    // Outputs are decoded from the next state so every port comes straight off a flop.
    always_comb begin
        w_pll_rst_nxt = (w_next_state == c_ST_PLL_RESET) || (w_next_state == c_ST_FAULT);
        w_ready_nxt   = (w_next_state == c_ST_RUN);
        w_fault_nxt   = (w_next_state == c_ST_FAULT);
        w_rst_out_nxt = '0;
        if (w_next_state == c_ST_RUN) begin
            w_rst_out_nxt = '1;
        end else if ((r_state == c_ST_RELEASE) && (w_next_state == c_ST_RELEASE)) begin
            for (int i = 0; i < NUM_OUT; i++) begin
                w_rst_out_nxt[i] = (r_cnt >= CNT_W'(i * STAGGER));
            end
        end

        w_retry_nxt = r_retry;
        if (force_relock || w_lock_loss) begin
            w_retry_nxt = '0;
        end else if (w_timeout && (w_next_state == c_ST_PLL_RESET)) begin
            w_retry_nxt = r_retry + 1'b1;
        end

        w_cnt_nxt = r_cnt;
        if (force_relock || (w_next_state != r_state)) begin
            w_cnt_nxt = '0;
        end else if (w_counting && (r_cnt != CNT_W'(CNT_MAX))) begin
            w_cnt_nxt = r_cnt + 1'b1;
        end
    end

    assign pll_rst   = r_pll_rst;
    assign rst_out_n = r_rst_out_n;
    assign ready     = r_ready;
    assign fault     = r_fault;
    assign retry_cnt = r_retry;

endmodule
`default_nettype wire

// File: tb/tb_pll_lock_supervisor.sv
`default_nettype none
// ============================================================================
// Module   : tb_pll_lock_supervisor
// Purpose  : Self-checking bench: vector table, directed corner sequences and
//            randomized lock behaviour against a phase/elapsed-time model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pll_lock_supervisor;

    localparam int NUM_OUT = 3;
    localparam int PRC     = 4;
    localparam int LF      = 8;
    localparam int LT      = 32;
    localparam int STG     = 2;
    localparam int MR      = 2;

    logic       refclk = 1'b0;
    logic       rst_n  = 1'b0;
    logic       pll_locked = 1'b0;
    logic       force_relock = 1'b0;
    logic       pll_rst;
    logic [2:0] rst_out_n;
    logic       ready;
    logic       fault;
    logic [1:0] retry_cnt;

    int checks = 0;
    int errors = 0;

    pll_lock_supervisor #(
        .NUM_OUT        (NUM_OUT),
        .PLL_RST_CYCLES (PRC),
        .LOCK_FILTER    (LF),
        .LOCK_TIMEOUT   (LT),
        .STAGGER        (STG),
        .MAX_RETRIES    (MR)
    ) dut (
        .refclk       (refclk),
        .rst_n        (rst_n),
        .pll_locked   (pll_locked),
        .force_relock (force_relock),
        .pll_rst      (pll_rst),
        .rst_out_n    (rst_out_n),
        .ready        (ready),
        .fault        (fault),
        .retry_cnt    (retry_cnt)
    );

    always #5 refclk = ~refclk;

    // Reference model: named phase, cycles elapsed in it, and a history of raw lock samples.
    typedef enum int {P_RESET, P_WAIT, P_FILTER, P_RELEASE, P_RUN, P_FAULT} phase_t;
    phase_t m_phase;
    int     m_t;
    int     m_retry;
    bit     m_hist[$];

    typedef struct {
        bit         f;
        bit         l;
        logic [7:0] exp;
    } vec_t;
    vec_t tbl[20];

    function automatic vec_t mk(input bit f, input bit l, input bit prst, input logic [2:0] ron,
                                input bit rdy, input bit flt, input logic [1:0] rc);
        vec_t v;
        v.f   = f;
        v.l   = l;
        v.exp = {prst, ron, rdy, flt, rc};
        return v;
    endfunction

    function automatic logic [7:0] dut_out();
        return {pll_rst, rst_out_n, ready, fault, retry_cnt};
    endfunction

    function automatic logic [7:0] m_out();
        logic [2:0] ron;
        ron = '0;
        if (m_phase == P_RUN) begin
            ron = '1;
        end else if (m_phase == P_RELEASE) begin
            for (int i = 0; i < NUM_OUT; i++) ron[i] = (m_t >= i * STG + 1);
        end
        return {(m_phase == P_RESET) || (m_phase == P_FAULT), ron,
                m_phase == P_RUN, m_phase == P_FAULT, 2'(m_retry)};
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got pll_rst=%b rst_out_n=%b ready=%b fault=%b retry=%0d, expected pll_rst=%b rst_out_n=%b ready=%b fault=%b retry=%0d (t=%0t)",
                     name, act[7], act[6:4], act[3], act[2], act[1:0],
                     exp[7], exp[6:4], exp[3], exp[2], exp[1:0], $time);
        end
    endtask

    task automatic check_val(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic enter(input phase_t p);
        m_phase = p;
        m_t     = 0;
    endtask

    task automatic model_reset();
        m_phase = P_RESET;
        m_t     = 0;
        m_retry = 0;
        m_hist.delete();
        m_hist.push_back(1'b0);
        m_hist.push_back(1'b0);
    endtask

    task automatic model_step(input bit f, input bit l);
        bit ls;
        ls = m_hist[0];
        m_hist.push_back(l);
        void'(m_hist.pop_front());
        if (f) begin
            m_retry = 0;
            enter(P_RESET);
        end else begin
            case (m_phase)
                P_RESET:   if (m_t == PRC - 1) enter(P_WAIT); else m_t++;
                P_WAIT: begin
                    if (ls) enter(P_FILTER);
                    else if (m_t == LT - 1) begin
                        if (m_retry == MR) enter(P_FAULT);
                        else begin
                            m_retry++;
                            enter(P_RESET);
                        end
                    end else m_t++;
                end
                P_FILTER:  if (!ls) enter(P_WAIT); else if (m_t == LF - 1) enter(P_RELEASE); else m_t++;
                P_RELEASE: begin
                    if (!ls) begin
                        m_retry = 0;
                        enter(P_RESET);
                    end else if (m_t == (NUM_OUT - 1) * STG + 1) enter(P_RUN);
                    else m_t++;
                end
                P_RUN: begin
                    if (!ls) begin
                        m_retry = 0;
                        enter(P_RESET);
                    end
                end
                default: ;
            endcase
        end
    endtask

    task automatic cycle(input bit f, input bit l);
        force_relock = f;
        pll_locked   = l;
        @(posedge refclk);
        model_step(f, l);
        #1;
        check("model_cmp", dut_out(), m_out());
    endtask

    task automatic do_reset(input bit l);
        rst_n        = 1'b0;
        force_relock = 1'b0;
        pll_locked   = l;
        repeat (3) @(posedge refclk);
        #1;
        model_reset();
        check("reset_state", dut_out(), 8'h80);
        rst_n = 1'b1;
    endtask

    task automatic run_until_ready(input string name);
        int n;
        n = 0;
        while (ready !== 1'b1 && n < 200) begin
            cycle(1'b0, 1'b1);
            n++;
        end
        check_val(name, int'(ready), 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: bench did not reach its summary, got time %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int rises;
        int early;
        logic prev;

        tbl[0]  = mk(0, 1, 1, 3'b000, 0, 0, 2'd0);
        tbl[1]  = mk(0, 1, 1, 3'b000, 0, 0, 2'd0);
        tbl[2]  = mk(0, 1, 1, 3'b000, 0, 0, 2'd0);
        tbl[3]  = mk(0, 1, 0, 3'b000, 0, 0, 2'd0);
        tbl[4]  = mk(0, 1, 0, 3'b000, 0, 0, 2'd0);
        tbl[5]  = mk(0, 1, 0, 3'b000, 0, 0, 2'd0);
        tbl[6]  = mk(0, 1, 0, 3'b000, 0, 0, 2'd0);
        tbl[7]  = mk(0, 1, 0, 3'b000, 0, 0, 2'd0);
        tbl[8]  = mk(0, 1, 0, 3'b000, 0, 0, 2'd0);
        tbl[9]  = mk(0, 1, 0, 3'b000, 0, 0, 2'd0);
        tbl[10] = mk(0, 1, 0, 3'b000, 0, 0, 2'd0);
        tbl[11] = mk(0, 1, 0, 3'b000, 0, 0, 2'd0);
        tbl[12] = mk(0, 1, 0, 3'b000, 0, 0, 2'd0);
        tbl[13] = mk(0, 1, 0, 3'b001, 0, 0, 2'd0);
        tbl[14] = mk(0, 1, 0, 3'b001, 0, 0, 2'd0);
        tbl[15] = mk(0, 1, 0, 3'b011, 0, 0, 2'd0);
        tbl[16] = mk(0, 1, 0, 3'b011, 0, 0, 2'd0);
        tbl[17] = mk(0, 1, 0, 3'b111, 0, 0, 2'd0);
        tbl[18] = mk(0, 1, 0, 3'b111, 1, 0, 2'd0);
        tbl[19] = mk(0, 1, 0, 3'b111, 1, 0, 2'd0);

        // Nominal power-up with lock tied high.
        do_reset(1'b1);
        for (int i = 0; i < 20; i++) begin
            cycle(tbl[i].f, tbl[i].l);
            check($sformatf("nominal_e%0d", i + 1), dut_out(), tbl[i].exp);
        end

        // Lock loss in RUN: two sync cycles, then everything drops on one edge.
        cycle(1'b0, 1'b0);
        check("runloss_k", dut_out(), 8'h78);
        cycle(1'b0, 1'b0);
        check("runloss_k1", dut_out(), 8'h78);
        cycle(1'b0, 1'b1);
        check("runloss_k2", dut_out(), 8'h80);
        run_until_ready("runloss_resequence");

        // Lock loss after only bit0 has been released.
        do_reset(1'b1);
        for (int e = 1; e <= 13; e++) cycle(1'b0, 1'b1);
        cycle(1'b0, 1'b0);
        check("relloss_e14", dut_out(), 8'h10);
        cycle(1'b0, 1'b1);
        check("relloss_e15", dut_out(), 8'h10);
        cycle(1'b0, 1'b1);
        check("relloss_e16", dut_out(), 8'h80);
        cycle(1'b0, 1'b1);
        check("relloss_e17", dut_out(), 8'h80);

        // One-cycle lock glitch after five filtered cycles restarts qualification.
        do_reset(1'b1);
        early = 0;
        for (int e = 1; e <= 26; e++) begin
            cycle(1'b0, e != 9);
            if (e <= 20 && rst_out_n != 3'b000) early++;
            if (e == 21) check("glitch_e21", dut_out(), 8'h10);
            if (e == 25) check("glitch_e25", dut_out(), 8'h70);
            if (e == 26) check("glitch_e26", dut_out(), 8'h78);
        end
        check_val("glitch_no_early_release", early, 0);

        // Lock never arrives: initial reset plus two retries, then fault.
        do_reset(1'b0);
        rises = 0;
        prev  = pll_rst;
        for (int e = 1; e <= 108; e++) begin
            cycle(1'b0, 1'b0);
            if (e <= 107 && pll_rst && !prev) rises++;
            prev = pll_rst;
            if (e == 35)  check("timeout_e35", dut_out(), 8'h00);
            if (e == 36)  check("timeout_retry1", dut_out(), 8'h81);
            if (e == 72)  check("timeout_retry2", dut_out(), 8'h82);
            if (e == 107) check("timeout_e107", dut_out(), 8'h02);
            if (e == 108) check("fault_entry", dut_out(), 8'h86);
        end
        check_val("timeout_pll_rst_rises", rises, 2);
        for (int e = 0; e < 5; e++) cycle(1'b0, 1'b1);
        check("fault_sticky", dut_out(), 8'h86);
        cycle(1'b1, 1'b1);
        check("fault_cleared_by_relock", dut_out(), 8'h80);

        // Async reset between edges takes effect immediately.
        run_until_ready("async_reach_run");
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_immediate", dut_out(), 8'h80);
        do_reset(1'b1);

        // force_relock coincident with lock loss.
        run_until_ready("relock_reach_run");
        cycle(1'b0, 1'b0);
        check("relock_loss_k", dut_out(), 8'h78);
        cycle(1'b0, 1'b0);
        check("relock_loss_k1", dut_out(), 8'h78);
        cycle(1'b1, 1'b0);
        check("relock_and_loss", dut_out(), 8'h80);

        // Randomized lock activity with rare relock requests.
        for (int n = 0; n < 3000;) begin
            int len;
            bit lv;
            len = $urandom_range(1, 70);
            lv  = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 9) == 0) begin
                len = 150;
                lv  = 1'b0;
            end
            for (int j = 0; j < len; j++) begin
                cycle($urandom_range(0, 299) == 0, lv);
                n++;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
